// File: rtl/wash_actuator_if.sv
// Bundle of command strobes, sensor inputs and actuator drives between the
// wash-program processor side and the actuator driver.
`timescale 1ns/1ps
interface wash_actuator_if;
    logic ctrl_fill;
    logic ctrl_release;
    logic ctrl_forward;
    logic ctrl_reverse;
    logic water_full;
    logic fault_clr;
    logic valve_in;
    logic valve_out;
    logic motor_fwd;
    logic motor_rev;
    logic fault;

    // Command/sensor side: drives requests, observes actuators.
    modport master (
        output ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse,
        output water_full, fault_clr,
        input  valve_in, valve_out, motor_fwd, motor_rev, fault
    );

    // Driver side: consumes requests, drives actuators.
    modport slave (
        input  ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse,
        input  water_full, fault_clr,
        output valve_in, valve_out, motor_fwd, motor_rev, fault
    );
endinterface

// File: rtl/wash_actuator_driver.sv
// Wash actuator driver: turns processor strobes into valve and motor drives
// with motor dead time, valve switch-over gap, fill cutoff on the level
// sensor and a sticky fault on conflicting commands. All drives registered.
`timescale 1ns/1ps
module wash_actuator_driver #(
    parameter int unsigned DEAD_TIME = 4,
    parameter int unsigned VALVE_GAP = 2,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    wash_actuator_if.slave bus
);

    typedef enum logic [1:0] {M_IDLE, M_FWD, M_REV, M_DEAD} motor_state_t;
    typedef enum logic [1:0] {V_IDLE, V_FILL, V_DRAIN, V_GAP} valve_state_t;

    // Counters hold "remaining cycles minus one", so the wait is exactly N.
    localparam logic [CNT_WIDTH-1:0] DEAD_LOAD = CNT_WIDTH'(DEAD_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(VALVE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    motor_state_t         m_state_q, m_state_d;
    valve_state_t         v_state_q, v_state_d;
    logic [CNT_WIDTH-1:0] m_cnt_q, m_cnt_d;
    logic [CNT_WIDTH-1:0] v_cnt_q, v_cnt_d;
    logic                 fault_q, fault_d;
    logic                 motor_fwd_q, motor_rev_q;
    logic                 valve_in_q, valve_out_q;

    logic conflict;
    logic fwd_req, rev_req, fill_req, drn_req, fill_ok;

    // Request qualification and sticky fault next state (set wins over clear).
    always_comb begin
        conflict = (bus.ctrl_fill & bus.ctrl_release) |
                   (bus.ctrl_forward & bus.ctrl_reverse);
        fwd_req  = bus.ctrl_forward & ~bus.ctrl_reverse & ~fault_q;
        rev_req  = bus.ctrl_reverse & ~bus.ctrl_forward & ~fault_q;
        fill_req = bus.ctrl_fill & ~bus.ctrl_release & ~fault_q;
        drn_req  = bus.ctrl_release & ~bus.ctrl_fill & ~fault_q;
        fill_ok  = fill_req & ~bus.water_full;
        fault_d  = fault_q;
        if (conflict) begin
            fault_d = 1'b1;
        end else if (bus.fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // Motor FSM: any stop or reversal passes through a DEAD_TIME off window.
    always_comb begin
        m_state_d = m_state_q;
        m_cnt_d   = m_cnt_q;
        unique case (m_state_q)
            M_IDLE: begin
                if (fwd_req) begin
                    m_state_d = M_FWD;
                end else if (rev_req) begin
                    m_state_d = M_REV;
                end
            end
            M_FWD: begin
                if (!fwd_req) begin
                    m_state_d = M_DEAD;
                    m_cnt_d   = DEAD_LOAD;
                end
            end
            M_REV: begin
                if (!rev_req) begin
                    m_state_d = M_DEAD;
                    m_cnt_d   = DEAD_LOAD;
                end
            end
            M_DEAD: begin
                if (m_cnt_q != '0) begin
                    m_cnt_d = m_cnt_q - CNT_ONE;
                end else if (fwd_req) begin
                    m_state_d = M_FWD;
                end else if (rev_req) begin
                    m_state_d = M_REV;
                end else begin
                    m_state_d = M_IDLE;
                end
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    // Valve FSM: fill is cut off by the level sensor; any close opens a gap.
    always_comb begin
        v_state_d = v_state_q;
        v_cnt_d   = v_cnt_q;
        unique case (v_state_q)
            V_IDLE: begin
                if (fill_ok) begin
                    v_state_d = V_FILL;
                end else if (drn_req) begin
                    v_state_d = V_DRAIN;
                end
            end
            V_FILL: begin
                if (!fill_ok) begin
                    v_state_d = V_GAP;
                    v_cnt_d   = GAP_LOAD;
                end
            end
            V_DRAIN: begin
                if (!drn_req) begin
                    v_state_d = V_GAP;
                    v_cnt_d   = GAP_LOAD;
                end
            end
            V_GAP: begin
                if (v_cnt_q != '0) begin
                    v_cnt_d = v_cnt_q - CNT_ONE;
                end else if (fill_ok) begin
                    v_state_d = V_FILL;
                end else if (drn_req) begin
                    v_state_d = V_DRAIN;
                end else begin
                    v_state_d = V_IDLE;
                end
            end
            default: v_state_d = V_IDLE;
        endcase
    end

    // State, counters, fault and registered actuator drives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_state_q   <= M_IDLE;
            v_state_q   <= V_IDLE;
            m_cnt_q     <= '0;
            v_cnt_q     <= '0;
            fault_q     <= 1'b0;
            motor_fwd_q <= 1'b0;
            motor_rev_q <= 1'b0;
            valve_in_q  <= 1'b0;
            valve_out_q <= 1'b0;
        end else begin
            m_state_q   <= m_state_d;
            v_state_q   <= v_state_d;
            m_cnt_q     <= m_cnt_d;
            v_cnt_q     <= v_cnt_d;
            fault_q     <= fault_d;
            motor_fwd_q <= (m_state_d == M_FWD);
            motor_rev_q <= (m_state_d == M_REV);
            valve_in_q  <= (v_state_d == V_FILL);
            valve_out_q <= (v_state_d == V_DRAIN);
        end
    end

    assign bus.motor_fwd = motor_fwd_q;
    assign bus.motor_rev = motor_rev_q;
    assign bus.valve_in  = valve_in_q;
    assign bus.valve_out = valve_out_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_wash_actuator_driver.sv
// Bench for wash_actuator_driver: directed scenarios plus random traffic,
// every cycle compared against a behavioural interlock model.
`timescale 1ns/1ps
module tb_wash_actuator_driver;

    localparam int DEAD_TIME = 4;
    localparam int VALVE_GAP = 2;

    logic clk = 1'b0;
    logic rst_n;

    wash_actuator_if bus();

    wash_actuator_driver #(
        .DEAD_TIME(DEAD_TIME),
        .VALVE_GAP(VALVE_GAP),
        .CNT_WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: direction running (0 none, 1 fwd, 2 rev), edges during
    // which a new start is still forbidden, and the fault flag.
    int m_run = 0, m_blk = 0;
    int v_run = 0, v_blk = 0;
    bit f_mdl = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_ctrl(input bit fil, input bit rel, input bit fwd, input bit rev,
                            input bit full, input bit clr);
        bus.ctrl_fill    = fil;
        bus.ctrl_release = rel;
        bus.ctrl_forward = fwd;
        bus.ctrl_reverse = rev;
        bus.water_full   = full;
        bus.fault_clr    = clr;
    endtask

    task automatic model_edge(input bit rst, input bit fil, input bit rel, input bit fwd,
                              input bit rev, input bit full, input bit clr);
        bit fq, rq, fok, dq;
        if (!rst) begin
            m_run = 0; m_blk = 0; v_run = 0; v_blk = 0; f_mdl = 0;
            return;
        end
        fq  = fwd && !rev && !f_mdl;
        rq  = rev && !fwd && !f_mdl;
        fok = fil && !rel && !f_mdl && !full;
        dq  = rel && !fil && !f_mdl;
        // motor
        if (m_run != 0) begin
            if (!((m_run == 1 && fq) || (m_run == 2 && rq))) begin
                m_run = 0;
                m_blk = DEAD_TIME - 1;
            end
        end else if (m_blk > 0) begin
            m_blk--;
        end else if (fq) begin
            m_run = 1;
        end else if (rq) begin
            m_run = 2;
        end
        // valves
        if (v_run != 0) begin
            if (!((v_run == 1 && fok) || (v_run == 2 && dq))) begin
                v_run = 0;
                v_blk = VALVE_GAP - 1;
            end
        end else if (v_blk > 0) begin
            v_blk--;
        end else if (fok) begin
            v_run = 1;
        end else if (dq) begin
            v_run = 2;
        end
        // fault
        if ((fil && rel) || (fwd && rev)) f_mdl = 1;
        else if (clr) f_mdl = 0;
    endtask

    // One clock: model follows the sampled inputs, then all outputs compared.
    task automatic step();
        logic [4:0] got, exp;
        @(posedge clk);
        model_edge(rst_n, bus.ctrl_fill, bus.ctrl_release, bus.ctrl_forward,
                   bus.ctrl_reverse, bus.water_full, bus.fault_clr);
        #1;
        got = {bus.valve_in, bus.valve_out, bus.motor_fwd, bus.motor_rev, bus.fault};
        exp = {v_run == 1, v_run == 2, m_run == 1, m_run == 2, f_mdl};
        check_val("model", {3'b0, got}, {3'b0, exp});
    endtask

    task automatic idle(input int n);
        set_ctrl(0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctrl(1, 1, 1, 1, 1, 1);
        repeat (3) begin
            step();
            check_val("rst_hold", {3'b0, bus.valve_in, bus.valve_out, bus.motor_fwd,
                                   bus.motor_rev, bus.fault}, 8'h00);
        end
        rst_n = 1'b1;
        set_ctrl(0, 0, 0, 0, 0, 0);
        repeat (2) begin
            step();
            check_val("rst_rel", {3'b0, bus.valve_in, bus.valve_out, bus.motor_fwd,
                                  bus.motor_rev, bus.fault}, 8'h00);
        end

        // Reversal with dead time.
        for (int i = 0; i < 16; i++) begin
            set_ctrl(0, 0, i < 10, i >= 10, 0, 0);
            step();
            check_val("rev_fwd", {7'b0, bus.motor_fwd}, {7'b0, i <= 9});
            check_val("rev_rev", {7'b0, bus.motor_rev}, {7'b0, i >= 14});
        end
        idle(8);

        // Fill cutoff on level sensor, reopen after it falls.
        for (int i = 0; i < 15; i++) begin
            set_ctrl(1, 0, 0, 0, (i >= 5) && (i < 12), 0);
            step();
            check_val("fill_in", {7'b0, bus.valve_in},
                      {7'b0, ((i + 1) <= 5) || ((i + 1) >= 13)});
        end
        idle(6);

        // Fill to drain switch-over gap.
        for (int i = 0; i < 10; i++) begin
            set_ctrl(i < 4, i >= 4, 0, 0, 0, 0);
            step();
            check_val("sw_in", {7'b0, bus.valve_in}, {7'b0, i <= 3});
            check_val("sw_out", {7'b0, bus.valve_out}, {7'b0, i >= 6});
        end
        idle(6);

        // Conflict sets sticky fault; motor falls through dead time to idle.
        for (int i = 0; i < 30; i++) begin
            set_ctrl(0, 0, 1, i == 20, 0, 0);
            step();
            check_val("cf_fault", {7'b0, bus.fault}, {7'b0, i >= 20});
            check_val("cf_fwd", {7'b0, bus.motor_fwd}, {7'b0, i < 20});
        end
        set_ctrl(0, 0, 0, 1, 0, 1);
        step();
        check_val("clr_fault", {7'b0, bus.fault}, 8'h00);
        check_val("clr_rev0", {7'b0, bus.motor_rev}, 8'h00);
        set_ctrl(0, 0, 0, 1, 0, 0);
        step();
        check_val("clr_rev1", {7'b0, bus.motor_rev}, 8'h01);
        set_ctrl(0, 0, 1, 1, 0, 1);
        step();
        check_val("set_wins", {7'b0, bus.fault}, 8'h01);
        set_ctrl(0, 0, 0, 0, 0, 1);
        step();
        check_val("clr_again", {7'b0, bus.fault}, 8'h00);
        idle(8);

        // Reset in the middle of a dead time aborts the wait.
        set_ctrl(0, 0, 0, 1, 0, 0);
        repeat (3) step();
        check_val("md_run", {7'b0, bus.motor_rev}, 8'h01);
        set_ctrl(0, 0, 0, 0, 0, 0);
        step();
        set_ctrl(0, 0, 0, 1, 0, 0);
        step();
        check_val("md_dead", {7'b0, bus.motor_rev}, 8'h00);
        rst_n = 1'b0;
        step();
        check_val("md_rst", {7'b0, bus.motor_rev}, 8'h00);
        rst_n = 1'b1;
        step();
        check_val("md_after", {7'b0, bus.motor_rev}, 8'h01);
        idle(8);

        // Random traffic with held commands, occasional conflicts and resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 15);
                bus.ctrl_fill    = (r == 0) || (r >= 6 && r <= 10);
                bus.ctrl_release = (r == 0) || (r >= 11);
            end
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 15);
                bus.ctrl_forward = (r == 0) || (r >= 6 && r <= 10);
                bus.ctrl_reverse = (r == 0) || (r >= 11);
            end
            if ($urandom_range(0, 7) == 0) bus.water_full = ~bus.water_full;
            bus.fault_clr = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/wash_actuator_driver.md
Name: wash_actuator_driver

Overview:
- Sits directly downstream of the wash-program processor.
- Consumes its ctrl_fill / ctrl_release / ctrl_forward / ctrl_reverse strobes and drives the physical water valves and drum motor.
- Enforces safety interlocks: motor dead time on direction change, a valve switch-over gap, level-sensor cutoff on fill, and a sticky fault on conflicting commands.
- All actuator outputs are registered.

Parameters:
- DEAD_TIME, 4: motor-off cycles enforced after any motor stop or reversal; legal range 1..2^CNT_WIDTH-1.
- VALVE_GAP, 2: both-valves-closed cycles enforced after any valve closes; legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 8: width of the dead-time and gap down-counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ctrl_fill  in  1  request to open the inlet valve.
- ctrl_release  in  1  request to open the drain valve.
- ctrl_forward  in  1  request to run the motor forward.
- ctrl_reverse  in  1  request to run the motor reverse.
- water_full  in  1  level sensor; 1 = tub full.
- fault_clr  in  1  clears the sticky fault.
- valve_in  out  1  inlet valve drive.
- valve_out  out  1  drain valve drive.
- motor_fwd  out  1  motor forward drive.
- motor_rev  out  1  motor reverse drive.
- fault  out  1  sticky conflict flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both FSMs go to IDLE.
  - Counters reset to 0.
  - fault=0 and all outputs 0.
  - Reset mid-dead-time or mid-gap aborts the wait immediately.
- Requests are sampled at each clk edge:
  - fwd_req = ctrl_forward & ~ctrl_reverse & ~fault
  - rev_req = ctrl_reverse & ~ctrl_forward & ~fault
  - fill_req = ctrl_fill & ~ctrl_release & ~fault
  - drn_req = ctrl_release & ~ctrl_fill & ~fault
- Latency: a request sampled at edge n drives its output high from cycle n+1. Outputs are decoded from registered state only.
- Motor FSM states: M_IDLE, M_FWD, M_REV, M_DEAD.
  - M_IDLE: fwd_req -> M_FWD; rev_req -> M_REV; else stay.
  - M_FWD: fwd_req -> stay; otherwise -> M_DEAD and load cnt=DEAD_TIME-1. This includes rev_req, no request, and fault.
  - M_REV: symmetric to M_FWD.
  - M_DEAD: if cnt!=0, decrement. If cnt==0: fwd_req -> M_FWD, rev_req -> M_REV, else -> M_IDLE.
  - Net effect: exactly DEAD_TIME cycles with both motor outputs 0 between any two run periods.
  - Outputs: motor_fwd = (M_FWD), motor_rev = (M_REV). The two are never both 1.
- Valve FSM states: V_IDLE, V_FILL, V_DRAIN, V_GAP, with its own counter.
  - V_IDLE: fill_req & ~water_full -> V_FILL; drn_req -> V_DRAIN; else stay.
  - V_FILL: fill_req & ~water_full -> stay; otherwise -> V_GAP and load gcnt=VALVE_GAP-1.
  - V_DRAIN: drn_req -> stay; otherwise -> V_GAP and load gcnt=VALVE_GAP-1.
  - V_GAP: decrement until gcnt==0, then take the same transitions as V_IDLE.
  - Net effect: exactly VALVE_GAP closed cycles.
  - Outputs: valve_in = (V_FILL), valve_out = (V_DRAIN). The two are never both 1.
  - Draining ignores water_full; no empty sensor is used.
- Fault:
  - Set at an edge where (ctrl_fill & ctrl_release) | (ctrl_forward & ctrl_reverse) is sampled.
  - While set, all requests are masked, so running FSMs pass through DEAD/GAP to IDLE.
  - fault_clr=1 clears fault at the next edge unless a conflict is sampled on that same edge; set wins.
  - fault_clr does not shorten an in-progress dead time or gap.
- Motor and valve FSMs are independent. Simultaneous motor and valve activity is legal.
- Counters are CNT_WIDTH unsigned. Behaviour for DEAD_TIME=0 or VALVE_GAP=0 is out of range and need not be supported.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all ctrl inputs=1 -> all outputs 0 and fault=0. Release reset with inputs 0 -> outputs stay 0.
- Reversal (DEAD_TIME=4): ctrl_forward=1 cycles 0-9, then ctrl_reverse=1 from cycle 10 -> motor_fwd=1 cycles 1-10, both motor outputs 0 cycles 11-14, motor_rev=1 from cycle 15.
- Fill cutoff (VALVE_GAP=2): ctrl_fill=1 held, water_full rises in cycle 5 -> valve_in=1 cycles 1-5, gap cycles 6-7, IDLE from 8. valve_in stays 0 while water_full=1, and reopens one cycle after water_full falls.
- Fill-to-drain switch: ctrl_fill cycles 0-3, then ctrl_release from cycle 4 -> valve_in=1 cycles 1-4, both valves 0 cycles 5-6, valve_out=1 from 7.
- Conflict: motor running forward, then ctrl_forward=ctrl_reverse=1 in cycle 20 -> fault=1 from 21, motor dead cycles 21-24, then IDLE while fault is held.
  - Assert fault_clr with a clean ctrl_reverse -> fault=0 next cycle, motor_rev=1 one cycle after that.
  - fault_clr together with a conflict -> fault stays 1.
- Reset mid-dead: assert rst_n=0 during M_DEAD with ctrl_reverse=1 -> after release, motor_rev=1 one cycle later with no dead time.
